// File: rtl/seq_det_pkg.sv
// Shared types and constants for the dual-pattern serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        RUN  = 2'b10
    } state_t;

    localparam logic found    = 1'b1;
    localparam logic notfound = 1'b0;

    // Bits needed for a fill counter that must reach pat_w itself.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_dual_if.sv
// Bit stream, configuration and match-event bundle for seq_detector_dual.
interface seq_detector_dual_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat_a;
    logic [PAT_W-1:0] cfg_pat_b;
    logic             cfg_overlap;
    logic             found_a;
    logic             found_b;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;
    logic             armed;

    modport master (
        output x, x_valid, cfg_load, cfg_pat_a, cfg_pat_b, cfg_overlap,
        input  found_a, found_b, count_a, count_b, armed
    );

    modport slave (
        input  x, x_valid, cfg_load, cfg_pat_a, cfg_pat_b, cfg_overlap,
        output found_a, found_b, count_a, count_b, armed
    );
endinterface

// File: rtl/pattern_match_counter.sv
// One pattern slot: latched pattern, equality compare, registered found pulse and saturating count.
// Latency: found/count update on the edge that accepts the matching bit; no backpressure.
module pattern_match_counter
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic             cmp_en,
    input  logic [PAT_W-1:0] cand,
    output logic             hit,
    output logic             found_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        hit     = cmp_en && (cand == pat_q);
        pat_d   = pat_q;
        found_d = notfound;
        count_d = count_q;
        if (cfg_load) begin
            pat_d   = cfg_pat;
            count_d = '0;
        end else if (hit) begin
            found_d = found;
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= '0;
            found_q <= notfound;
            count_q <= '0;
        end else begin
            pat_q   <= pat_d;
            found_q <= found_d;
            count_q <= count_d;
        end
    end

    assign found_o = found_q;
    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_dual.sv
// Dual-pattern serial detector: FSM, shared history and overlap control around two match slots.
// Latency: match pulse registered on the edge that accepts the last pattern bit; x_valid low just holds.
module seq_detector_dual
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    seq_detector_dual_if.slave bus
);

    localparam int             FW        = fill_width(PAT_W);
    localparam logic [FW-1:0]  FILL_LAST = FW'(PAT_W - 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             ovl_q, ovl_d;
    logic             armed_q, armed_d;

    logic [PAT_W-1:0] cand;
    logic             cmp_en;
    logic             hit_a, hit_b;
    logic             hist_msb_unused;

    // The oldest history bit is shifted out before it is ever compared.
    assign hist_msb_unused = hist_q[PAT_W-1];
    assign cand            = {hist_q[PAT_W-2:0], bus.x};

    always_comb begin
        cmp_en = !bus.cfg_load && bus.x_valid &&
                 ((state_q == RUN) || ((state_q == FILL) && (fill_q == FILL_LAST)));
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        ovl_d   = ovl_q;
        if (bus.cfg_load) begin
            ovl_d   = bus.cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (bus.x_valid) begin
            unique case (state_q)
                FILL: begin
                    hist_d = cand;
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FILL_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    hist_d = cand;
                end
                default: begin
                end
            endcase
            // Non-overlap: a match on either pattern consumes the whole window.
            if (cmp_en && !ovl_q && (hit_a || hit_b)) begin
                fill_d  = '0;
                state_d = FILL;
            end
        end
        armed_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            ovl_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            ovl_q   <= ovl_d;
            armed_q <= armed_d;
        end
    end

    assign bus.armed = armed_q;

    pattern_match_counter #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_match_a (
        .clk      (clk),
        .reset    (reset),
        .cfg_load (bus.cfg_load),
        .cfg_pat  (bus.cfg_pat_a),
        .cmp_en   (cmp_en),
        .cand     (cand),
        .hit      (hit_a),
        .found_o  (bus.found_a),
        .count_o  (bus.count_a)
    );

    pattern_match_counter #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_match_b (
        .clk      (clk),
        .reset    (reset),
        .cfg_load (bus.cfg_load),
        .cfg_pat  (bus.cfg_pat_b),
        .cmp_en   (cmp_en),
        .cand     (cand),
        .hit      (hit_b),
        .found_o  (bus.found_b),
        .count_o  (bus.count_b)
    );

endmodule

// File: doc/seq_detector_dual.md
# seq_detector_dual

Parametrised, clocked dual-pattern serial sequence detector. It replaces the hard-coded three-bit Mealy detectors in the FSM exercises with a single block that provides:
- two run-time-loadable patterns of PAT_W bits;
- selectable overlapping or non-overlapping matching;
- a data-valid qualifier;
- registered match pulses and saturating per-pattern match counters.

It sits between a serial bit source and any consumer of match events or statistics.

## Interface
Parameters:
- PAT_W, 3, pattern length in bits (legal range 2..16)
- CNT_W, 8, width of each match counter

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- x  in  1  serial data bit
- x_valid  in  1  x is consumed on a posedge only when high
- cfg_load  in  1  latch cfg_pat_a, cfg_pat_b and cfg_overlap; restart detection
- cfg_pat_a  in  PAT_W  pattern A; MSB = oldest bit
- cfg_pat_b  in  PAT_W  pattern B; MSB = oldest bit
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- found_a  out  1  one-cycle registered pulse on a pattern A match
- found_b  out  1  one-cycle registered pulse on a pattern B match
- count_a  out  CNT_W  saturating count of A matches
- count_b  out  CNT_W  saturating count of B matches
- armed  out  1  high in FILL or RUN (configuration loaded)

## Operation
**Reset (reset low).** State = IDLE. The following are all cleared to 0:
- history register hist[PAT_W-1:0] and fill counter
- latched patterns and overlap flag
- found_a, found_b, count_a, count_b, armed

**FSM states.**
- IDLE: x ignored. cfg_load -> FILL.
- FILL: history not yet full. Each valid bit shifts in as hist <= {hist[PAT_W-2:0], x} and fill increments. The bit that makes fill == PAT_W moves to RUN and is compared in the same edge.
- RUN: each valid bit shifts in and is compared.
  - Overlap mode: stay in RUN.
  - Non-overlap mode, on a match of A or B: clear fill and return to FILL, so no bit is reused.
  - Non-overlap mode, no match: stay in RUN.

**Match rule.** Candidate word = {hist[PAT_W-2:0], x}, compared when fill reaches PAT_W with this bit.
- Candidate == pat_a: found_a = 1 for one cycle; count_a increments.
- Candidate == pat_b: found_b = 1 for one cycle; count_b increments.
- A and B may match on the same bit (including identical patterns): both fire; in non-overlap mode a single restart occurs.

**Counters.** Saturate at 2^CNT_W-1; they never wrap.

**cfg_load in any state.** Takes priority over x_valid on the same edge:
- latches the new patterns and overlap flag
- clears hist, fill and both counters
- found_a/found_b = 0 on that edge
- sets state = FILL
- discards any bit presented with x_valid on that edge

**x_valid low.** No shift and no compare; found outputs return to 0; the state holds.

## Timing
- Latency: a bit accepted at edge N produces found_a/found_b high from edge N until edge N+1. This is a registered Moore output and never combinational from x.
- count_x updates on the same edge as the corresponding found_x.
- Back-to-back matches in overlap mode produce found high on consecutive cycles.
- armed rises on the edge that samples cfg_load.
- Asserting reset mid-stream clears everything asynchronously. After reset deasserts, the block stays in IDLE until cfg_load.
- Minimum bits per match after cfg_load or a non-overlap restart: PAT_W.

## Structure
- Shared package seq_det_pkg:
  - state typedef: IDLE = 2'b00, FILL = 2'b01, RUN = 2'b10
  - defines found = 1, notfound = 0
- Sub-module pattern_match_counter, instantiated once per pattern. It contains:
  - the pattern register
  - the equality comparator
  - the found register
  - the saturating counter
- The top level holds the FSM, hist, fill and the overlap flag.

## Test plan
All scenarios use PAT_W = 3, CNT_W = 8 unless stated.

1. A = 111, B = 000, overlap = 1; valid stream 0,0,0,0,1,1,1,1 -> found_b after bits 3 and 4; found_a after bits 7 and 8; count_a = 2; count_b = 2.
2. A = 111, overlap = 0; stream 1,1,1,1,1,1,1 -> found_a after bits 3 and 6 only; count_a = 2; state FILL after bit 6.
3. A = 101; stream 1,0,1 with x_valid low for 2 cycles between each bit (x toggling garbage meanwhile) -> single found_a after the third valid bit; no spurious pulses.
4. CNT_W = 2, A = 111, overlap = 1; ten consecutive 1s -> found_a pulses 8 times; count_a = 3 (saturated).
5. A = B = 010; stream 0,1,0 -> found_a and found_b high on the same cycle; both counts = 1.
6. Mid-stream reset low after bits 1,1 -> all outputs 0 and state IDLE asynchronously; bits ignored until cfg_load. Then cfg_load with x_valid = 1 on the same edge -> that bit is discarded; three further 1s -> found_a once.
